// File: rtl/fft_frame_input_buffer.sv
// fft_frame_input_buffer: ping-pong frame buffer in front of the first FFT stage.
// Collects N-sample complex frames into one of two banks and replays each full
// frame on a second valid/ready stream. The two sides always work on opposite banks.
// Build option: define FFT_IN_BITREV_EN to replay frames in bit-reversed index
// order (DIT input ordering). Without it, frames are replayed in natural order.
module fft_frame_input_buffer #(
  parameter int WIDTH = 10,
  parameter int N     = 64,
  parameter int LOG2N = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [LOG2N-1:0] out_idx,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic             frame_err,
  output logic [15:0]      frame_cnt
);

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  logic [2*WIDTH-1:0] mem_q [0:2*N-1];

  logic [1:0]       full_q,      full_d;
  logic             wr_sel_q,    wr_sel_d;
  logic             rd_sel_q,    rd_sel_d;
  logic [LOG2N-1:0] wr_idx_q,    wr_idx_d;
  logic [LOG2N-1:0] rd_cnt_q,    rd_cnt_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             frame_err_q, frame_err_d;

  logic             wr_fire;
  logic             rd_fire;
  logic [LOG2N-1:0] rd_addr;
  logic [2*WIDTH-1:0] rd_word;

  assign in_ready  = !full_q[wr_sel_q];
  assign out_valid = full_q[rd_sel_q];
  assign wr_fire   = in_valid & in_ready;
  assign rd_fire   = out_valid & out_ready;
  assign out_last  = out_valid & (rd_cnt_q == LAST_IDX);
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

  // Read address: bit-reversed or natural replay order of the read counter.
  always_comb begin
    rd_addr = '0;
`ifdef FFT_IN_BITREV_EN
    for (int i = 0; i < LOG2N; i++) begin
      rd_addr[i] = rd_cnt_q[LOG2N-1-i];
    end
`else
    rd_addr = rd_cnt_q;
`endif
  end

  // Output data straight from the read bank; forced to zero while no frame is ready
  // so the outputs are defined after reset even though storage is never cleared.
  always_comb begin
    rd_word = mem_q[{rd_sel_q, rd_addr}];
    out_idx = rd_addr;
    out_re  = out_valid ? rd_word[2*WIDTH-1:WIDTH] : '0;
    out_im  = out_valid ? rd_word[WIDTH-1:0]       : '0;
  end

  // Sample storage: written on every accepted input, no reset on purpose.
  always_ff @(posedge clk) begin
    if (wr_fire && !rst) begin
      mem_q[{wr_sel_q, wr_idx_q}] <= {in_re, in_im};
    end
  end

  // Next-state for pointers, full flags and status. The full flags keep the two
  // sides on different banks, so completion and release can update them together.
  always_comb begin
    full_d      = full_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    wr_idx_d    = wr_idx_q;
    rd_cnt_d    = rd_cnt_q;
    frame_cnt_d = frame_cnt_q;
    frame_err_d = 1'b0;

    if (wr_fire) begin
      if (in_last && (wr_idx_q != LAST_IDX)) begin
        // early in_last: drop the partial frame, keep the bank empty
        frame_err_d = 1'b1;
        wr_idx_d    = '0;
      end else if (wr_idx_q == LAST_IDX) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = !wr_sel_q;
        wr_idx_d         = '0;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end

    if (rd_fire) begin
      if (rd_cnt_q == LAST_IDX) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = !rd_sel_q;
        rd_cnt_d         = '0;
        frame_cnt_d      = frame_cnt_q + 16'd1;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset; reset abandons any buffered frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q      <= '0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      wr_idx_q    <= '0;
      rd_cnt_q    <= '0;
      frame_cnt_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      wr_idx_q    <= wr_idx_d;
      rd_cnt_q    <= rd_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_fft_frame_input_buffer.sv
// tb_fft_frame_input_buffer: directed stimulus with a scoreboard of expected
// output samples. Honours FFT_IN_BITREV_EN for the expected replay order.
module tb_fft_frame_input_buffer;

  localparam int W = 10;
  localparam int N = 64;
  localparam int L = 6;

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic [L-1:0] idx;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_last;
  logic [W-1:0] in_re, in_im;
  logic         out_valid, out_ready, out_last;
  logic [L-1:0] out_idx;
  logic [W-1:0] out_re, out_im;
  logic         frame_err;
  logic [15:0]  frame_cnt;

  int checks = 0;
  int errors = 0;

  exp_t         sb[$];
  logic [2*W-1:0] pend [N];
  int           m_widx = 0;
  logic         exp_err = 1'b0;
  logic [15:0]  exp_fc = '0;
  logic         hold_v = 1'b0;
  logic [W-1:0] hold_re, hold_im;
  logic [L-1:0] hold_idx;
  logic         hold_last;
  int           cyc = 0;
  int           first_cyc = -1;
  int           last_cyc = -1;
  int           stall_cnt = 0;
  bit           rand_rdy = 1'b0;
  int           fno = 0;
  logic [15:0]  fc_start;
  bit           seen;

  fft_frame_input_buffer #(.WIDTH(W), .N(N), .LOG2N(L)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_idx(out_idx), .out_re(out_re), .out_im(out_im),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int brev(input int v);
    int r = 0;
    for (int i = 0; i < L; i++) r |= ((v >> i) & 1) << (L - 1 - i);
    return r;
  endfunction

  function automatic logic [W-1:0] dre(input int f, input int k);
    return W'((f * 37 + k) & ((1 << W) - 1));
  endfunction

  // Monitor and reference model, evaluated on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    int a;
    cyc++;
    if (rst) begin
      sb.delete();
      m_widx  = 0;
      exp_err = 1'b0;
      exp_fc  = '0;
      hold_v  = 1'b0;
    end else begin
      check("frame_err", 32'(frame_err), 32'(exp_err));
      check("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
      if (hold_v) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_re",    32'(out_re),    32'(hold_re));
        check("hold_im",    32'(out_im),    32'(hold_im));
        check("hold_idx",   32'(out_idx),   32'(hold_idx));
        check("hold_last",  32'(out_last),  32'(hold_last));
      end
      hold_v    = out_valid && !out_ready;
      hold_re   = out_re;
      hold_im   = out_im;
      hold_idx  = out_idx;
      hold_last = out_last;

      if (out_valid && out_ready) begin
        check("out_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out_re",   32'(out_re),   32'(e.re));
          check("out_im",   32'(out_im),   32'(e.im));
          check("out_idx",  32'(out_idx),  32'(e.idx));
          check("out_last", 32'(out_last), 32'(e.last));
          if (e.last) exp_fc = exp_fc + 16'd1;
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end

      exp_err = 1'b0;
      if (in_valid && in_ready) begin
        pend[m_widx] = {in_re, in_im};
        if (in_last && m_widx != N - 1) begin
          exp_err = 1'b1;
          m_widx  = 0;
        end else if (m_widx == N - 1) begin
          for (int c = 0; c < N; c++) begin
`ifdef FFT_IN_BITREV_EN
            a = brev(c);
`else
            a = c;
`endif
            e.re   = pend[a][2*W-1:W];
            e.im   = pend[a][W-1:0];
            e.idx  = L'(a);
            e.last = (c == N - 1);
            sb.push_back(e);
          end
          m_widx = 0;
        end else begin
          m_widx++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, input logic last);
    bit acc;
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    in_last  = last;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      acc = in_ready;
      if (!acc) stall_cnt++;
      tick();
      if (acc) return;
    end
    check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int len);
    for (int k = 0; k < len; k++) send(dre(fno, k), -dre(fno, k), k == len - 1);
    fno++;
  endtask

  task automatic drain();
    idle();
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        tick();
        return;
      end
      tick();
    end
    check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_idx",   32'(out_idx),   32'd0);
    check("rst_out_re",    32'(out_re),    32'd0);
    check("rst_out_im",    32'(out_im),    32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    tick();

    // 1: single frame, re=k im=-k, out_ready high
    out_ready = 1'b1;
    send_frame(N);
    check("t1_valid_latency", 32'(out_valid), 32'd1);
    drain();
    check("t1_frame_cnt", 32'(frame_cnt), 32'd1);

    // 2: three frames into a stalled output
    out_ready = 1'b0;
    send_frame(N);
    send_frame(N);
    idle();
    @(negedge clk);
    check("t2_in_ready_full", 32'(in_ready), 32'd0);
    tick();
    fc_start  = frame_cnt;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (frame_cnt != fc_start) begin
        seen = 1'b1;
        check("t2_in_ready_rise", 32'(in_ready), 32'd1);
      end
      tick();
    end
    check("t2_release_seen", 32'(seen), 32'd1);
    send_frame(N);
    drain();
    check("t2_frame_cnt", 32'(frame_cnt), 32'd4);

    // 3: early in_last drops the partial frame
    send_frame(21);
    check("t3_err_pulse", 32'(frame_err), 32'd1);
    idle();
    tick();
    check("t3_err_clear", 32'(frame_err), 32'd0);
    check("t3_no_output", 32'(out_valid), 32'd0);
    send_frame(N);
    drain();
    check("t3_frame_cnt", 32'(frame_cnt), 32'd5);

    // 4: random output backpressure over 10 frames
    rand_rdy = 1'b1;
    for (int f = 0; f < 10; f++) send_frame(N);
    drain();
    check("t4_frame_cnt", 32'(frame_cnt), 32'd15);

    // 5: reset while frame 0 drains and frame 1 is partly written
    out_ready = 1'b0;
    send_frame(N);
    out_ready = 1'b1;
    for (int k = 0; k < 30; k++) send(dre(fno, k), -dre(fno, k), 1'b0);
    fno++;
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_in_ready",  32'(in_ready),  32'd1);
    check("t5_frame_cnt", 32'(frame_cnt), 32'd0);
    tick();
    send_frame(N);
    drain();
    check("t5_fresh_cnt", 32'(frame_cnt), 32'd1);

    // 6: continuous streaming, bank switches on both sides in the same cycle
    out_ready = 1'b1;
    stall_cnt = 0;
    first_cyc = -1;
    for (int f = 0; f < 3; f++) send_frame(N);
    drain();
    check("t6_no_in_stall", 32'(stall_cnt), 32'd0);
    check("t6_out_span",    32'(last_cyc - first_cyc), 32'(3 * N - 1));
    check("t6_frame_cnt",   32'(frame_cnt), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
